// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative RV32M multiply/divide sequencer.
// MULDIV_EARLY_OUT_EN (see muldiv_seq) does not change anything here.
package muldiv_pkg;
    localparam int XLEN  = 32;
    localparam int CNT_W = 6;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIXUP, S_DONE} state_t;

    function automatic logic a_is_signed(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic b_is_signed(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction
endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate; purely combinational, width set by W.
module muldiv_signfix #(
    parameter int W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] res_o
);
    assign res_o = neg_i ? (~val_i + W'(1)) : val_i;
endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M mul/div on a borrowed ALU: accept -> first-valid edge is 35 cycles (3 on early-out).
// Optional MULDIV_EARLY_OUT_EN skips ITER for zero operands, divide-by-zero and DIV overflow.
module muldiv_seq
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            alu_own,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_op,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_c
);
    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d, res_q, res_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              neg_a_q, neg_a_d, neg_b_q, neg_b_d;

    logic [XLEN-1:0]   mag_a, mag_b, quo_fix, rem_fix, rem_src;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN:0]     csum;
    logic              div_op, b_zero, div_ovf, early_out, sub_ok;

    assign div_op = op_q[2];
    assign b_zero = (b_q == '0);
    // Evaluated in FIXUP, when a_q/b_q already hold magnitudes.
    assign div_ovf = div_op & ~op_q[0] & neg_a_q & neg_b_q & (a_q == INT_MIN) & (b_q == XLEN'(1));
`ifdef MULDIV_EARLY_OUT_EN
    assign early_out = div_op ? (b_zero | (~op_q[0] & (a_q == INT_MIN) & (b_q == '1)))
                              : ((a_q == '0) | b_zero);
`else
    assign early_out = 1'b0;
`endif
    assign sub_ok  = hi_q[XLEN-1] | ~alu_c;
    // Dividing by zero leaves the dividend as remainder, even when ITER was skipped.
    assign rem_src = b_zero ? a_q : hi_q;

    muldiv_signfix #(.W(XLEN)) u_mag_a (.val_i(a_q), .neg_i(a_is_signed(op_q) & a_q[XLEN-1]), .res_o(mag_a));
    muldiv_signfix #(.W(XLEN)) u_mag_b (.val_i(b_q), .neg_i(b_is_signed(op_q) & b_q[XLEN-1]), .res_o(mag_b));
    muldiv_signfix #(.W(2*XLEN)) u_fix_prod (.val_i({hi_q, lo_q}), .neg_i(neg_a_q ^ neg_b_q), .res_o(prod_fix));
    muldiv_signfix #(.W(XLEN)) u_fix_quo (.val_i(lo_q), .neg_i(neg_a_q ^ neg_b_q), .res_o(quo_fix));
    muldiv_signfix #(.W(XLEN)) u_fix_rem (.val_i(rem_src), .neg_i(neg_a_q), .res_o(rem_fix));

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_DONE);
    assign resp_data  = res_q;

    always_comb begin
        alu_own = (state_q == S_ITER);
        alu_a   = '0;
        alu_b   = '0;
        alu_op  = ALU_ADD;
        if (alu_own) begin
            if (div_op) begin
                alu_op = ALU_SUB;
                alu_a  = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
                alu_b  = b_q;
            end else if (b_q[0]) begin
                alu_a = hi_q;
                alu_b = a_q;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        csum    = b_q[0] ? {alu_c, alu_result} : {1'b0, hi_q};
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    a_d     = req_a;
                    b_d     = req_b;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                neg_a_d = a_is_signed(op_q) & a_q[XLEN-1];
                neg_b_d = b_is_signed(op_q) & b_q[XLEN-1];
                a_d     = mag_a;
                b_d     = mag_b;
                hi_d    = '0;
                lo_d    = div_op ? mag_a : '0;
                cnt_d   = '0;
                state_d = early_out ? S_FIXUP : S_ITER;
            end
            S_ITER: begin
                if (div_op) begin
                    hi_d = sub_ok ? alu_result : {hi_q[XLEN-2:0], lo_q[XLEN-1]};
                    lo_d = {lo_q[XLEN-2:0], sub_ok};
                end else begin
                    {hi_d, lo_d} = {csum, lo_q[XLEN-1:1]};
                    b_d          = b_q >> 1;
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(XLEN-1)) state_d = S_FIXUP;
            end
            S_FIXUP: begin
                case (op_q)
                    OP_MUL:                       res_d = prod_fix[XLEN-1:0];
                    OP_MULH, OP_MULHSU, OP_MULHU: res_d = prod_fix[2*XLEN-1:XLEN];
                    OP_DIV, OP_DIVU:              res_d = b_zero ? '1 : (div_ovf ? INT_MIN : quo_fix);
                    default:                      res_d = div_ovf ? '0 : rem_fix;
                endcase
                state_d = S_DONE;
            end
            S_DONE: begin
                if (resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq with an add/sub ALU behind the alu_own mux.
module tb_muldiv_seq;
    logic        clk = 1'b0;
    logic        reset, req_valid, req_ready, resp_valid, resp_ready, alu_own, alu_c;
    logic [2:0]  req_op;
    logic [31:0] req_a, req_b, resp_data, alu_a, alu_b, alu_result;
    logic [3:0]  alu_op;
    logic [31:0] core_a = '0, core_b = '0, mx_a, mx_b;
    logic [3:0]  core_op = '0, mx_op;

    typedef struct {
        logic [31:0] data;
        int          lat;
        int          own;
        logic [2:0]  op;
    } exp_t;
    exp_t exp_q[$];
    exp_t e;

    int          checks = 0, errors = 0, cyc = 0;
    int          acc_edge = 0, own_cnt = 0;
    bit          in_resp = 0;
    logic [31:0] held = '0;

    always #5 clk = ~clk;

    muldiv_seq dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .alu_own(alu_own), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_c(alu_c)
    );

    // Shared ALU: the core drives it unless the sequencer owns it.
    always @(posedge clk) begin
        core_a  <= $urandom;
        core_b  <= $urandom;
        core_op <= 4'($urandom_range(0, 1));
        cyc     <= cyc + 1;
    end

    always_comb begin
        mx_a  = alu_own ? alu_a  : core_a;
        mx_b  = alu_own ? alu_b  : core_b;
        mx_op = alu_own ? alu_op : core_op;
        if (mx_op == 4'b0001) {alu_c, alu_result} = {1'b0, mx_a} - {1'b0, mx_b};
        else                  {alu_c, alu_result} = {1'b0, mx_a} + {1'b0, mx_b};
    end

    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        p  = 0;
        case (op)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        if (op >= 3'd4) begin
            if (b == 0) return 3;
            if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 3;
        end else if (a == 0 || b == 0) begin
            return 3;
        end
`endif
        return 35;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: measures accept-to-first-valid edge distance and ALU ownership per transaction.
    always @(negedge clk) begin
        if (reset) begin
            in_resp = 0;
        end else begin
            if (alu_own) own_cnt++;
            if (req_valid && req_ready) begin
                acc_edge = cyc + 1;
                own_cnt  = 0;
            end
            if (resp_valid) begin
                chk("busy_req_ready", {31'b0, req_ready}, 32'd0);
                if (!in_resp) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_resp got %h want none", resp_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk($sformatf("resp_data op%0d", e.op), resp_data, e.data);
                        chk($sformatf("latency op%0d", e.op), 32'(cyc + 1 - acc_edge), 32'(e.lat));
                        chk($sformatf("alu_own_cycles op%0d", e.op), 32'(own_cnt), 32'(e.own));
                    end
                    held    = resp_data;
                    in_resp = 1;
                end else begin
                    chk("hold_stable", resp_data, held);
                end
                if (resp_ready) in_resp = 0;
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t x;
        int   n;
        x.data = ref_res(op, a, b);
        x.lat  = exp_lat(op, a, b);
        x.own  = (x.lat == 35) ? 32 : 0;
        x.op   = op;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout got req_ready=0 want 1");
        end else begin
            exp_q.push_back(x);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || resp_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout got %0d pending want 0", exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_alu_own", {31'b0, alu_own}, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_alu_op", {28'b0, alu_op}, 32'd0);

        issue(3'd0, 32'd7, 32'd6);
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(3'd1, 32'h8000_0000, 32'h8000_0000);
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(3'd4, -32'sd7, 32'd2);
        issue(3'd6, -32'sd7, 32'd2);
        issue(3'd5, 32'd100, 32'd7);
        issue(3'd7, 32'd100, 32'd7);
        issue(3'd5, 32'h1234_5678, 32'd0);
        issue(3'd6, 32'd5, 32'd0);
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(3'd1, 32'd0, 32'hDEAD_BEEF);
        drain();

        // Consumer stalls: result must hold and new requests must be refused.
        resp_ready = 1'b0;
        issue(3'd5, 32'd100, 32'd7);
        n = 0;
        while (!resp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("stall_resp_seen", {31'b0, resp_valid}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = 3'd0; req_a = 32'd9; req_b = 32'd9;
        repeat (10) begin
            @(negedge clk);
            chk("stall_resp_valid", {31'b0, resp_valid}, 32'd1);
        end
        @(posedge clk); #1;
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        drain();

        // Abort mid-ITER via reset, then a fresh request must still work.
        issue(3'd0, 32'd5, 32'd7);
        repeat (13) @(posedge clk);
        #1;
        chk("abort_in_iter_alu_own", {31'b0, alu_own}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        chk("abort_req_ready", {31'b0, req_ready}, 32'd1);
        chk("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("abort_alu_own", {31'b0, alu_own}, 32'd0);
        issue(3'd0, 32'd3, 32'd3);
        drain();

        repeat (40) issue(3'($urandom_range(0, 7)), pick(), pick());
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
